// File: rtl/irq_controller_if.sv
// Bus between the interrupt controller and its surroundings: the raw sources
// and mask port coming in, the CPU interrupt pins and status going out.
interface irq_controller_if #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic [NUM_SRC-1:0] irqSrc;
    logic               nmiSrc;
    logic               maskWrite;
    logic [NUM_SRC-1:0] maskData;
    logic               ackIrq;
    logic               ackNmi;
    logic               interruptRequest;
    logic               nonMaskableInterrupt;
    logic [ID_W-1:0]    irqId;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;

    // Board / CPU side: drives sources, mask writes and acknowledges
    modport master (
        output irqSrc, nmiSrc, maskWrite, maskData, ackIrq, ackNmi,
        input  interruptRequest, nonMaskableInterrupt, irqId, pending, mask
    );

    // Controller side
    modport slave (
        input  irqSrc, nmiSrc, maskWrite, maskData, ackIrq, ackNmi,
        output interruptRequest, nonMaskableInterrupt, irqId, pending, mask
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller in front of top8227. Synchronizes and edge-detects
// NUM_SRC maskable sources plus one NMI, latches edges into pending bits,
// selects the lowest-index enabled pending source and drives the CPU IRQ/NMI
// pins through an ack/holdoff state machine.
module irq_controller #(
    parameter int NUM_SRC = 8,
    parameter int HOLDOFF = 2
) (
    input logic            clk,
    input logic            rst,
    irq_controller_if.slave bus
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IRQ_ACT = 2'd1;
    localparam logic [1:0] S_NMI_ACT = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [3:0] HOLDOFF_VAL = 4'(HOLDOFF);

    // Input synchronizers and edge history
    logic [NUM_SRC-1:0] irq_sync1_q, irq_sync1_d;
    logic [NUM_SRC-1:0] irq_sync2_q, irq_sync2_d;
    logic [NUM_SRC-1:0] irq_hist_q,  irq_hist_d;
    logic               nmi_sync1_q, nmi_sync1_d;
    logic               nmi_sync2_q, nmi_sync2_d;
    logic               nmi_hist_q,  nmi_hist_d;

    // Architectural state
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               nmi_pending_q, nmi_pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [3:0]         hold_cnt_q, hold_cnt_d;

    // Combinational helpers
    logic [NUM_SRC-1:0] irq_edge;
    logic               nmi_edge;
    logic [NUM_SRC-1:0] eligible;
    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    logic               irq_clr;
    logic               nmi_clr;

    // Two-flop synchronizer followed by a one-cycle history flop; an edge is
    // a synchronized 1 whose previous value was 0. History resets to 0, so a
    // source held high across reset yields exactly one edge afterwards.
    always_comb begin
        irq_sync1_d = bus.irqSrc;
        irq_sync2_d = irq_sync1_q;
        irq_hist_d  = irq_sync2_q;
        nmi_sync1_d = bus.nmiSrc;
        nmi_sync2_d = nmi_sync1_q;
        nmi_hist_d  = nmi_sync2_q;
        irq_edge    = irq_sync2_q & ~irq_hist_q;
        nmi_edge    = nmi_sync2_q & ~nmi_hist_q;
    end

    // Lowest-index enabled pending source wins arbitration
    always_comb begin
        eligible = pending_q & mask_q;
        win_vld  = |eligible;
        win_id   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win_id = ID_W'(i);
        end
    end

    // Service FSM: NMI always wins, an active IRQ is pre-empted by NMI or
    // dropped if its mask bit goes away, and every acknowledge is followed
    // by HOLDOFF cycles in HOLD before re-arbitration.
    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        hold_cnt_d = hold_cnt_q;
        irq_clr    = 1'b0;
        nmi_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (nmi_pending_q) begin
                    state_d = S_NMI_ACT;
                end else if (win_vld) begin
                    state_d  = S_IRQ_ACT;
                    irq_id_d = win_id;
                end
            end
            S_IRQ_ACT: begin
                if (nmi_pending_q) begin
                    // pre-empted: pending bit stays for later service
                    state_d = S_NMI_ACT;
                end else if (!mask_q[irq_id_q]) begin
                    state_d = S_IDLE;
                end else if (bus.ackIrq) begin
                    irq_clr    = 1'b1;
                    hold_cnt_d = HOLDOFF_VAL;
                    state_d    = S_HOLD;
                end
            end
            S_NMI_ACT: begin
                if (bus.ackNmi) begin
                    nmi_clr    = 1'b1;
                    hold_cnt_d = HOLDOFF_VAL;
                    state_d    = S_HOLD;
                end
            end
            default: begin
                // S_HOLD: leave on the cycle the counter reads 1
                if (hold_cnt_q <= 4'd1) begin
                    hold_cnt_d = 4'd0;
                    state_d    = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
        endcase
    end

    // Pending and mask update; a fresh edge beats a same-cycle clear
    always_comb begin
        pending_d = pending_q;
        if (irq_clr) pending_d[irq_id_q] = 1'b0;
        pending_d     = pending_d | irq_edge;
        nmi_pending_d = (nmi_pending_q & ~nmi_clr) | nmi_edge;
        mask_d        = bus.maskWrite ? bus.maskData : mask_q;
    end

    // All state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_sync1_q   <= '0;
            irq_sync2_q   <= '0;
            irq_hist_q    <= '0;
            nmi_sync1_q   <= 1'b0;
            nmi_sync2_q   <= 1'b0;
            nmi_hist_q    <= 1'b0;
            pending_q     <= '0;
            nmi_pending_q <= 1'b0;
            mask_q        <= '0;
            state_q       <= S_IDLE;
            irq_id_q      <= '0;
            hold_cnt_q    <= 4'd0;
        end else begin
            irq_sync1_q   <= irq_sync1_d;
            irq_sync2_q   <= irq_sync2_d;
            irq_hist_q    <= irq_hist_d;
            nmi_sync1_q   <= nmi_sync1_d;
            nmi_sync2_q   <= nmi_sync2_d;
            nmi_hist_q    <= nmi_hist_d;
            pending_q     <= pending_d;
            nmi_pending_q <= nmi_pending_d;
            mask_q        <= mask_d;
            state_q       <= state_d;
            irq_id_q      <= irq_id_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    // Moore outputs decoded from registered state
    assign bus.interruptRequest     = (state_q == S_IRQ_ACT);
    assign bus.nonMaskableInterrupt = (state_q == S_NMI_ACT);
    assign bus.irqId                = (state_q == S_IRQ_ACT) ? irq_id_q : '0;
    assign bus.pending              = pending_q;
    assign bus.mask                 = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: inputs change and outputs are sampled
// on the falling clock edge, one task per scenario.
module tb_irq_controller;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    irq_controller_if #(.NUM_SRC(8)) bus();

    irq_controller #(.NUM_SRC(8), .HOLDOFF(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle to the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.maskWrite = 1'b1;
        bus.maskData  = m;
        step();
        bus.maskWrite = 1'b0;
    endtask

    // single-cycle pulse on a set of sources, leaves them low
    task automatic pulse_src(input logic [7:0] s);
        bus.irqSrc = s;
        step();
        bus.irqSrc = 8'h00;
    endtask

    // acknowledge the active IRQ and let holdoff fully expire
    task automatic ack_and_drain();
        bus.ackIrq = 1'b1;
        step();
        bus.ackIrq = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.interruptRequest !== 1'b0 || bus.nonMaskableInterrupt !== 1'b0) begin
            fails++; $display("FAIL reset_pins: irq=%0b nmi=%0b exp 0 0", bus.interruptRequest, bus.nonMaskableInterrupt); end
        checks++; if (bus.pending !== 8'h00 || bus.mask !== 8'h00 || bus.irqId !== 3'd0) begin
            fails++; $display("FAIL reset_regs: pending=%h mask=%h id=%0d exp 00 00 0", bus.pending, bus.mask, bus.irqId); end
    endtask

    task automatic test_basic();
        write_mask(8'hFF);
        pulse_src(8'h20);   // E0
        step();             // E1
        step();             // E2: pending set
        checks++; if (bus.pending !== 8'h20 || bus.interruptRequest !== 1'b0) begin
            fails++; $display("FAIL basic_pend: pending=%h irq=%0b exp 20 0", bus.pending, bus.interruptRequest); end
        step();             // E3: IRQ_ACT
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd5) begin
            fails++; $display("FAIL basic_irq: irq=%0b id=%0d exp 1 5", bus.interruptRequest, bus.irqId); end
        bus.ackIrq = 1'b1;
        step();             // A: HOLD
        bus.ackIrq = 1'b0;
        checks++; if (bus.pending !== 8'h00 || bus.interruptRequest !== 1'b0 || bus.irqId !== 3'd0) begin
            fails++; $display("FAIL basic_ack: pending=%h irq=%0b id=%0d exp 00 0 0", bus.pending, bus.interruptRequest, bus.irqId); end
        step();
        step();             // A+2: IDLE
        step();
        checks++; if (bus.interruptRequest !== 1'b0 || bus.nonMaskableInterrupt !== 1'b0) begin
            fails++; $display("FAIL basic_idle: irq=%0b nmi=%0b exp 0 0", bus.interruptRequest, bus.nonMaskableInterrupt); end
    endtask

    task automatic test_priority();
        pulse_src(8'h44);
        step();
        step();
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd2 || bus.pending !== 8'h44) begin
            fails++; $display("FAIL prio_first: irq=%0b id=%0d pending=%h exp 1 2 44", bus.interruptRequest, bus.irqId, bus.pending); end
        bus.ackIrq = 1'b1;
        step();             // A
        bus.ackIrq = 1'b0;
        step();             // A+1
        step();             // A+2: IDLE
        checks++; if (bus.interruptRequest !== 1'b0 || bus.pending !== 8'h40) begin
            fails++; $display("FAIL prio_hold: irq=%0b pending=%h exp 0 40", bus.interruptRequest, bus.pending); end
        step();             // A+3: IRQ_ACT again
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd6) begin
            fails++; $display("FAIL prio_second: irq=%0b id=%0d exp 1 6", bus.interruptRequest, bus.irqId); end
        ack_and_drain();
    endtask

    task automatic test_nmi_preempt();
        pulse_src(8'h08);
        step();
        step();
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd3) begin
            fails++; $display("FAIL nmi_pre_irq: irq=%0b id=%0d exp 1 3", bus.interruptRequest, bus.irqId); end
        bus.nmiSrc = 1'b1;
        step();             // E0
        bus.nmiSrc = 1'b0;
        step();             // E1
        step();             // E2: nmiPending set, still IRQ_ACT
        checks++; if (bus.interruptRequest !== 1'b1 || bus.nonMaskableInterrupt !== 1'b0) begin
            fails++; $display("FAIL nmi_sync: irq=%0b nmi=%0b exp 1 0", bus.interruptRequest, bus.nonMaskableInterrupt); end
        step();             // E3: NMI_ACT
        checks++; if (bus.interruptRequest !== 1'b0 || bus.nonMaskableInterrupt !== 1'b1 || bus.pending !== 8'h08) begin
            fails++; $display("FAIL nmi_act: irq=%0b nmi=%0b pending=%h exp 0 1 08", bus.interruptRequest, bus.nonMaskableInterrupt, bus.pending); end
        bus.ackNmi = 1'b1;
        step();             // A
        bus.ackNmi = 1'b0;
        checks++; if (bus.nonMaskableInterrupt !== 1'b0 || bus.interruptRequest !== 1'b0) begin
            fails++; $display("FAIL nmi_ack: irq=%0b nmi=%0b exp 0 0", bus.interruptRequest, bus.nonMaskableInterrupt); end
        step();
        step();
        step();             // A+3: IRQ 3 resumes
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd3 || bus.nonMaskableInterrupt !== 1'b0) begin
            fails++; $display("FAIL nmi_resume: irq=%0b id=%0d nmi=%0b exp 1 3 0", bus.interruptRequest, bus.irqId, bus.nonMaskableInterrupt); end
        ack_and_drain();
    endtask

    task automatic test_mask();
        write_mask(8'h00);
        pulse_src(8'h02);
        step();
        step();
        step();
        checks++; if (bus.pending !== 8'h02 || bus.interruptRequest !== 1'b0) begin
            fails++; $display("FAIL mask_block: pending=%h irq=%0b exp 02 0", bus.pending, bus.interruptRequest); end
        bus.maskWrite = 1'b1;
        bus.maskData  = 8'h02;
        step();             // write edge
        bus.maskWrite = 1'b0;
        checks++; if (bus.mask !== 8'h02 || bus.interruptRequest !== 1'b0) begin
            fails++; $display("FAIL mask_write: mask=%h irq=%0b exp 02 0", bus.mask, bus.interruptRequest); end
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd1) begin
            fails++; $display("FAIL mask_enable: irq=%0b id=%0d exp 1 1", bus.interruptRequest, bus.irqId); end
        ack_and_drain();
    endtask

    task automatic test_mask_drop();
        write_mask(8'hFF);
        pulse_src(8'h80);
        step();
        step();
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd7) begin
            fails++; $display("FAIL drop_irq: irq=%0b id=%0d exp 1 7", bus.interruptRequest, bus.irqId); end
        write_mask(8'h7F);  // mask changes, FSM reacts next edge
        step();
        checks++; if (bus.interruptRequest !== 1'b0 || bus.pending !== 8'h80) begin
            fails++; $display("FAIL drop_idle: irq=%0b pending=%h exp 0 80", bus.interruptRequest, bus.pending); end
        write_mask(8'hFF);
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd7) begin
            fails++; $display("FAIL drop_reenable: irq=%0b id=%0d exp 1 7", bus.interruptRequest, bus.irqId); end
        ack_and_drain();
    endtask

    task automatic test_back_to_back();
        pulse_src(8'h10);
        step();
        step();
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd4) begin
            fails++; $display("FAIL b2b_irq: irq=%0b id=%0d exp 1 4", bus.interruptRequest, bus.irqId); end
        bus.irqSrc = 8'h10;
        step();             // sync1
        step();             // sync2: edge visible this cycle
        bus.ackIrq = 1'b1;
        step();             // A: ack and new edge together
        bus.ackIrq = 1'b0;
        bus.irqSrc = 8'h00;
        checks++; if (bus.pending !== 8'h10 || bus.interruptRequest !== 1'b0) begin
            fails++; $display("FAIL b2b_setwins: pending=%h irq=%0b exp 10 0", bus.pending, bus.interruptRequest); end
        step();
        step();
        step();             // A+3
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd4) begin
            fails++; $display("FAIL b2b_reraise: irq=%0b id=%0d exp 1 4", bus.interruptRequest, bus.irqId); end
        ack_and_drain();
        step();
        bus.ackNmi = 1'b1;  // stray, must be ignored
        step();
        bus.ackNmi = 1'b0;
        step();
        step();
        checks++; if (bus.pending !== 8'h00 || bus.interruptRequest !== 1'b0 || bus.nonMaskableInterrupt !== 1'b0) begin
            fails++; $display("FAIL stray_ack: pending=%h irq=%0b nmi=%0b exp 00 0 0", bus.pending, bus.interruptRequest, bus.nonMaskableInterrupt); end
    endtask

    task automatic test_reset_mid();
        write_mask(8'h01);
        bus.irqSrc = 8'h01;  // held high through reset
        step();
        step();
        step();
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd0) begin
            fails++; $display("FAIL rst_pre: irq=%0b id=%0d exp 1 0", bus.interruptRequest, bus.irqId); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.interruptRequest !== 1'b0 || bus.pending !== 8'h00 || bus.mask !== 8'h00) begin
            fails++; $display("FAIL rst_mid: irq=%0b pending=%h mask=%h exp 0 00 00", bus.interruptRequest, bus.pending, bus.mask); end
        step();
        step();
        checks++; if (bus.pending !== 8'h00) begin
            fails++; $display("FAIL rst_sync: pending=%h exp 00", bus.pending); end
        step();
        checks++; if (bus.pending !== 8'h01 || bus.interruptRequest !== 1'b0) begin
            fails++; $display("FAIL rst_edge: pending=%h irq=%0b exp 01 0", bus.pending, bus.interruptRequest); end
        step();
        step();
        checks++; if (bus.pending !== 8'h01 || bus.interruptRequest !== 1'b0) begin
            fails++; $display("FAIL rst_masked: pending=%h irq=%0b exp 01 0", bus.pending, bus.interruptRequest); end
        write_mask(8'h01);
        step();
        checks++; if (bus.interruptRequest !== 1'b1 || bus.irqId !== 3'd0) begin
            fails++; $display("FAIL rst_enable: irq=%0b id=%0d exp 1 0", bus.interruptRequest, bus.irqId); end
        bus.irqSrc = 8'h00;
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.irqSrc    = 8'h00;
        bus.nmiSrc    = 1'b0;
        bus.maskWrite = 1'b0;
        bus.maskData  = 8'h00;
        bus.ackIrq    = 1'b0;
        bus.ackNmi    = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_priority();
        test_nmi_preempt();
        test_mask();
        test_mask_drop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
